// File: rtl/correlation_mac_pkg.sv
// Shared definitions for the streaming correlator: FSM state encoding and
// the result-width derivation used by the top level.
package correlation_mac_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Result width that can hold TAPS full-scale products without wrapping.
  function automatic int calc_out_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/correlation_mac_mac_unit.sv
// Single multiply-accumulate unit: unsigned product added into a registered
// accumulator, with synchronous clear taking priority over enable.
module mac_unit #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int OUT_W  = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [COEF_W-1:0] b_i,
  output logic [OUT_W-1:0]  acc_o
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic [PROD_W-1:0] prod;
  logic [OUT_W-1:0]  acc_q;
  logic [OUT_W-1:0]  acc_d;

  assign prod = {{COEF_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(OUT_W-PROD_W){1'b0}}, prod};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/correlation_mac.sv
// Streaming correlator: sliding sample window, loadable coefficients and one
// time-multiplexed MAC producing sum_k w[k]*h[k] per accepted sample.
module correlation_mac
  import correlation_mac_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int TAPS   = 10,
  parameter int OUT_W  = calc_out_w(DATA_W, COEF_W, TAPS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int AW = $clog2(TAPS);
  localparam int FW = $clog2(TAPS + 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(TAPS - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(TAPS);

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [FW-1:0]     fill_q, fill_d, fill_after;
  logic [DATA_W-1:0] win_q  [TAPS];
  logic [COEF_W-1:0] coef_q [TAPS];
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;
  logic [OUT_W-1:0]  acc;
  logic              accept, start_mac, coef_wr_ok, mac_en, acc_clr;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // the source must hold in_data stable while in_valid is high and in_ready is low.
  assign accept     = in_valid && in_ready;
  assign fill_after = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
  assign start_mac  = accept && (fill_after == FILL_FULL);
  assign fill_d     = accept ? fill_after : fill_q;
  assign coef_wr_ok = (state_q == ST_IDLE) && coef_we && (coef_addr <= LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_mac) state_d = ST_MAC;
      ST_MAC:  if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_IDLE);
    busy     = (state_q == ST_MAC) || (state_q == ST_DONE);
    mac_en   = (state_q == ST_MAC);
    acc_clr  = (state_q == ST_IDLE);
  end

  // Index walks 0..TAPS-1 during MAC and parks at 0 otherwise.
  always_comb begin
    idx_d = '0;
    if (state_q == ST_MAC && idx_q != LAST_IDX) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        win_q[k]  <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      fill_q      <= fill_d;
      idx_q       <= idx_d;
      out_valid_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        out_data_q <= acc;
      end
      if (accept) begin
        win_q[0] <= in_data;
        for (int k = 1; k < TAPS; k++) begin
          win_q[k] <= win_q[k-1];
        end
      end
      if (coef_wr_ok) begin
        coef_q[coef_addr] <= coef_data;
      end
    end
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .clr_i (acc_clr),
    .en_i  (mac_en),
    .a_i   (win_q[idx_q]),
    .b_i   (coef_q[idx_q]),
    .acc_o (acc)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_correlation_mac.sv
// Directed bench for correlation_mac: hand-computed results, handshake timing,
// ignored coefficient writes, reset during MAC and a randomly gapped stream.
module tb_correlation_mac;
  import correlation_mac_pkg::*;

  localparam int DATA_W = 4;
  localparam int COEF_W = 4;
  localparam int TAPS   = 10;
  localparam int OUT_W  = 12;
  localparam int AW     = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              busy;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [OUT_W-1:0] got_q[$];
  int               got_cyc[$];
  logic [OUT_W-1:0] exp_q[$];

  int h1[TAPS] = '{5, 10, 2, 6, 13, 14, 1, 9, 8, 15};

  correlation_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .OUT_W  (OUT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Result monitor: records every out_valid pulse and the edge it followed.
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      got_q.push_back(out_data);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_results();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    clear_results();
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = addr[AW-1:0];
    coef_data = data[COEF_W-1:0];
    tick(1);
    coef_we   = 1'b0;
  endtask

  task automatic send_sample(input int d, output int acc_edge);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d[DATA_W-1:0];
    while (in_ready !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    acc_edge = cyc + 1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: in_ready=%b required 1", in_ready);
    end
    tick(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++;
    if (out_data !== 12'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    n_tests++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_fill_first_result();
    int e;
    for (int k = 0; k < TAPS; k++) write_coef(k, h1[k]);
    for (int s = 1; s <= 9; s++) send_sample(s, e);
    tick(TAPS + 3);
    n_tests++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL no_early_result: got %0d results want 0", got_q.size()); end
    send_sample(10, e);
    drain();
    n_tests++;
    if (got_q.size() != 1) begin
      n_fail++;
      $display("FAIL first_result_count: got %0d want 1", got_q.size());
    end else begin
      n_tests++;
      if (got_q[0] !== 12'd408) begin n_fail++; $display("FAIL first_result: got %0d want 408", got_q[0]); end
      n_tests++;
      if (got_cyc[0] != e + TAPS + 1) begin
        n_fail++;
        $display("FAIL first_latency: got edge %0d want %0d", got_cyc[0], e + TAPS + 1);
      end
    end
    n_tests++;
    if (out_data !== 12'd408) begin n_fail++; $display("FAIL result_held: got %0d want 408", out_data); end
    clear_results();
  endtask

  task automatic test_ready_window();
    int e;
    int n;
    send_sample(0, e);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      n++;
      tick(1);
    end
    n_tests++;
    if (n != TAPS + 1) begin n_fail++; $display("FAIL ready_low_cycles: got %0d want %0d", n, TAPS + 1); end
    tick(2);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 12'd436) begin
      n_fail++;
      $display("FAIL second_result: got n=%0d val=%0d want n=1 val=436", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 12'd0);
    end
    clear_results();
  endtask

  task automatic test_back_to_back();
    int e1;
    int e2;
    send_sample(3, e1);
    send_sample(4, e2);
    drain();
    n_tests++;
    if (e2 - e1 != TAPS + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", e2 - e1, TAPS + 2); end
    n_tests++;
    if (got_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 2", got_q.size());
    end else begin
      n_tests++;
      if (got_q[0] !== 12'd419) begin n_fail++; $display("FAIL b2b_first: got %0d want 419", got_q[0]); end
      n_tests++;
      if (got_q[1] !== 12'd500) begin n_fail++; $display("FAIL b2b_second: got %0d want 500", got_q[1]); end
    end
    clear_results();
  endtask

  task automatic test_full_scale();
    int e;
    for (int k = 0; k < TAPS; k++) write_coef(k, 15);
    for (int s = 0; s < 9; s++) send_sample(15, e);
    drain();
    clear_results();
    send_sample(15, e);
    drain();
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 12'h8CA) begin
      n_fail++;
      $display("FAIL full_scale: got n=%0d val=%0d want n=1 val=2250", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 12'd0);
    end
    clear_results();
  endtask

  task automatic test_ignored_writes();
    int e;
    send_sample(15, e);
    tick(2);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_during_mac: got %b want 1", busy); end
    write_coef(0, 0);
    drain();
    clear_results();
    write_coef(12, 0);
    send_sample(15, e);
    drain();
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 12'd2250) begin
      n_fail++;
      $display("FAIL ignored_writes: got n=%0d val=%0d want n=1 val=2250", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 12'd0);
    end
    clear_results();
  endtask

  task automatic test_reset_mid_mac();
    int e;
    send_sample(15, e);
    tick(3);
    n_tests++;
    if (dbg_state !== ST_MAC) begin n_fail++; $display("FAIL mac_state: got %0d want %0d", dbg_state, ST_MAC); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(TAPS + 4);
    n_tests++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_discard: got %0d results want 0", got_q.size()); end
    n_tests++;
    if (out_data !== 12'd0) begin n_fail++; $display("FAIL reset_out_cleared: got %0d want 0", out_data); end
    for (int k = 0; k < TAPS; k++) write_coef(k, h1[k]);
    for (int s = 0; s < 9; s++) send_sample(2, e);
    drain();
    n_tests++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL refill_early: got %0d results want 0", got_q.size()); end
    send_sample(2, e);
    drain();
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 12'd166) begin
      n_fail++;
      $display("FAIL refill_result: got n=%0d val=%0d want n=1 val=166", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 12'd0);
    end
    clear_results();
  endtask

  task automatic test_random_gaps();
    int wm[TAPS];
    int hm[TAPS];
    int fill;
    int sum;
    int d;
    int e;
    logic [OUT_W-1:0] exp_v;
    do_reset();
    exp_q.delete();
    fill = 0;
    for (int k = 0; k < TAPS; k++) begin
      hm[k] = $urandom_range(0, 15);
      wm[k] = 0;
      write_coef(k, hm[k]);
    end
    for (int i = 0; i < 30; i++) begin
      tick($urandom_range(0, 3));
      d = $urandom_range(0, 15);
      send_sample(d, e);
      for (int k = TAPS - 1; k >= 1; k--) wm[k] = wm[k-1];
      wm[0] = d;
      if (fill < TAPS) fill++;
      if (fill == TAPS) begin
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += wm[k] * hm[k];
        exp_q.push_back(sum[OUT_W-1:0]);
      end
    end
    drain();
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stream_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got_q[0] !== exp_v) begin n_fail++; $display("FAIL stream_value: got %0d want %0d", got_q[0], exp_v); end
      void'(got_q.pop_front());
    end
    clear_results();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset     = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    tick(1);
    test_reset();
    test_fill_first_result();
    test_ready_window();
    test_back_to_back();
    test_full_scale();
    test_ignored_writes();
    test_reset_mid_mac();
    test_random_gaps();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
